alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Round-robin arbiter and sequencer that shares one 32-bit ALU (`alu_32bit`) among `NUM_REQ` requesters. Each requester issues an operation over a valid/ready request channel and gets the result on a per-requester valid/ready response channel. The block captures operands into registers, runs the ALU for one cycle, registers the result and zero flag, and holds the response until the owner accepts it. It sits between the issue logic of the requesting units and the single ALU instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default `$clog2(NUM_REQ)`: width of the grant index (derived, not overridden).

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: bit i means requester i presents an op.
- `req_ready`  out  NUM_REQ: bit i means requester i's op is accepted this cycle.
- `req_a`  in  NUM_REQ*32: operand A, requester i at bits [32i+31:32i].
- `req_b`  in  NUM_REQ*32: operand B, same packing.
- `req_op`  in  NUM_REQ*4: opcode, requester i at bits [4i+3:4i].
- `rsp_valid`  out  NUM_REQ: one-hot; response pending for requester i.
- `rsp_ready`  in  NUM_REQ: requester i accepts its response.
- `rsp_result`  out  32: shared result bus, meaningful while any `rsp_valid` bit is set.
- `rsp_zero`  out  1: result == 0.
- `rsp_err`  out  1: illegal opcode flag (see Configuration).
- `busy`  out  1: high when not IDLE.
- `grant_id`  out  IDW: index of the current or last granted requester.

## Operation
- Opcodes match the ALU: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0110 SLL by b[4:0], 0111 SRL by b[4:0]. All others give result 0.
- States:
  - IDLE: if any `req_valid` is set, pick the first set bit searching upward from `rr_ptr` with wrap. Assert that requester's `req_ready` combinationally in the same cycle. Capture a/b/op into operand registers, latch `grant_id`, go to EXEC. With no valid requests, stay in IDLE.
  - EXEC: the ALU sees only the operand registers. Register `result`, `zero` and `err`, then go to RESP.
  - RESP: assert `rsp_valid[grant_id]` only. When `rsp_ready[grant_id]` is high, go to IDLE and set `rr_ptr = (grant_id+1) mod NUM_REQ`.
- `req_ready` is 0 in EXEC and RESP, and is never asserted for more than one bit.
- A requester must hold valid and its payload until ready. Payload changes after acceptance have no effect.
- `rsp_ready` bits of non-granted requesters are ignored.
- Arithmetic is modulo 2^32: ADD/SUB wrap with no carry or overflow output. Shift amounts of 32 or more are impossible because only b[4:0] is used.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `req_ready` 0, `rsp_valid` 0, `rsp_result` 0, `rsp_zero` 0, `rsp_err` 0, `busy` 0.
- Handshake at cycle T (IDLE): EXEC at T+1, `rsp_valid` rises at T+2.
- With `rsp_ready` already high, the response completes at T+2, IDLE at T+3, and the next accept at T+3. Peak throughput is one op per 3 cycles.
- Response backpressure holds `rsp_*` stable for any number of cycles.
- Reset during EXEC or RESP aborts the transaction: no response, and the pointer returns to 0.
- A requester may raise `req_valid` in the same cycle it accepts its response. It is considered in the following IDLE cycle, at lowest priority for that round.

## Configuration
- `ALU_ARB_ILLEGAL_OP_EN` defined:
  - Opcodes 0101 and 1000–1111 set `rsp_err`=1 with `rsp_result`=0 and `rsp_zero`=1.
  - Legal opcodes give `rsp_err`=0.
- Undefined: `rsp_err` is tied 0 and illegal opcodes return 0 with zero=1, silently.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (`OP_ADD`…`OP_SRL`);
  - `alu_op_t` 4-bit typedef;
  - `arb_state_t` enum {IDLE, EXEC, RESP};
  - `is_legal_op()` function.
- `alu_32bit` is instantiated unchanged.
- One new sub-module, `rr_pick`: combinational, NUM_REQ request vector plus pointer in, one-hot grant plus index plus any-valid out.

## Test plan
- Single op: after reset, req0 ADD a=0xFFFF_FFFF, b=1, `rsp_ready` held high → `req_ready[0]` at T, `rsp_valid[0]` at T+2, result 0, zero=1.
- Round robin: all four valid continuously with ADD of distinct values, responses always ready → grant order 0,1,2,3,0; each response 3 cycles apart.
- Backpressure: req2 SUB 5−7, `rsp_ready[2]` low for 10 cycles → result 0xFFFF_FFFE held stable, zero=0, no new `req_ready` until acceptance.
- Shift boundaries: SLL a=1, b=0x3F → 0x8000_0000; SRL a=0x8000_0000, b=32 → 0x8000_0000 (b[4:0]=0).
- Illegal op 1010 with macro defined → result 0, zero=1, err=1. With macro undefined → err=0.
- Reset in RESP: assert `rst` while `rsp_valid[1]` is high → next cycle all outputs at reset values; a subsequent req3 request is granted before req0 only if req0 is idle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode definitions, arbiter state encoding and opcode legality helper
// for the shared-ALU arbiter.
package alu_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t OP_ADD = 4'b0000;
  localparam alu_op_t OP_SUB = 4'b0001;
  localparam alu_op_t OP_AND = 4'b0010;
  localparam alu_op_t OP_OR  = 4'b0011;
  localparam alu_op_t OP_XOR = 4'b0100;
  localparam alu_op_t OP_SLL = 4'b0110;
  localparam alu_op_t OP_SRL = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic is_legal_op(alu_op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU: add/sub/logic/shift, unknown opcodes yield 0.
module alu_32bit
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  always_comb begin
    int j;
    logic [IDW-1:0] jj;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j  = (int'(ptr) + k) % NUM_REQ;
      jj = IDW'(j);
      if (!any && req[jj]) begin
        grant[jj] = 1'b1;
        idx       = jj;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one alu_32bit among NUM_REQ requesters with round-robin grant.
// Define ALU_ARB_ILLEGAL_OP_EN to report illegal opcodes on rsp_err.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]  req_op,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid holds its payload until then, ready never waits on
  // a future cycle.

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  alu_op_t        op_q, op_d;
  logic [31:0]    result_q, result_d;
  logic           zero_q, zero_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic [31:0]        alu_result;
  logic               alu_zero;
  logic               rsp_accept;

  logic [31:0] a_arr  [NUM_REQ];
  logic [31:0] b_arr  [NUM_REQ];
  alu_op_t     op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[32*g +: 32];
    assign b_arr[g]  = req_b[32*g +: 32];
    assign op_arr[g] = req_op[4*g +: 4];
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The ALU only ever sees the captured operands, never live request buses.
  alu_32bit u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign rsp_accept = rsp_ready[grant_id_q];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != IDLE);
    if (state_q == IDLE) req_ready = pick_oh;
    if (state_q == RESP) rsp_valid[grant_id_q] = 1'b1;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    zero_d     = zero_q;
    if (state_q == IDLE && pick_any) begin
      grant_id_d = pick_idx;
      a_d        = a_arr[pick_idx];
      b_d        = b_arr[pick_idx];
      op_d       = op_arr[pick_idx];
    end
    if (state_q == EXEC) begin
      result_d = alu_result;
      zero_d   = alu_zero;
    end
    if (state_q == RESP && rsp_accept) begin
      rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == EXEC) err_d = !is_legal_op(op_q);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised scoreboard bench for alu_share_arbiter: a transaction-level
// round-robin model predicts grants, response timing and ALU results.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } op_t;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*4-1:0]  req_op;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           rsp_result;
  logic                  rsp_zero;
  logic                  rsp_err;
  logic                  busy;
  logic [IDW-1:0]        grant_id;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  op_t ops [NUM_REQ][$];
  int  rdy_mode [NUM_REQ];       // 0 always ready, 1 held low, 2 random
  logic [NUM_REQ-1:0] acc;
  logic [33:0] exp_q [$];        // {err, zero, result}

  int m_ptr, m_id, m_gid, m_age;
  logic m_busy;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference ALU from the opcode table.
  function automatic logic [33:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    logic [31:0] r;
    logic legal;
    legal = 1'b1;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: r = a << (b % 32);
      4'd7: r = a >> (b % 32);
      default: begin r = 32'd0; legal = 1'b0; end
    endcase
`ifdef ALU_ARB_ILLEGAL_OP_EN
    return {!legal, (r == 32'd0), r};
`else
    return {1'b0, (r == 32'd0), r};
`endif
  endfunction

  // driver tasks
  task automatic push_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    op_t o;
    o.a = a; o.b = b; o.op = op;
    ops[r].push_back(o);
  endtask

  function automatic bit ops_empty();
    for (int i = 0; i < NUM_REQ; i++) if (ops[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(ops_empty() && req_valid == '0 && !m_busy && exp_q.size() == 0)) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", (n < budget), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input int r, input int budget);
    int n;
    n = 0;
    while (n < budget && !rsp_valid[r]) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_wait_timeout", rsp_valid[r], 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
  endtask

  // Request driver: holds valid until accepted, then loads the next op.
  initial begin
    op_t o;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && ops[i].size() != 0) begin
          o = ops[i].pop_front();
          req_a[32*i +: 32] = o.a;
          req_b[32*i +: 32] = o.b;
          req_op[4*i +: 4]  = o.op;
          req_valid[i]      = 1'b1;
        end
        case (rdy_mode[i])
          0:       rsp_ready[i] = 1'b1;
          1:       rsp_ready[i] = 1'b0;
          default: rsp_ready[i] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // Monitor + scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] e_rdy;
    logic [NUM_REQ-1:0] e_rv;
    int j, g;
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_gid = 0; m_age = 0; m_id = 0;
      exp_q.delete();
      acc = '0;
    end else begin
      if (m_busy) m_age++;
      e_rdy = '0;
      g = -1;
      if (!m_busy) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          j = (m_ptr + k) % NUM_REQ;
          if (g < 0 && req_valid[j]) g = j;
        end
        if (g >= 0) e_rdy[g] = 1'b1;
      end
      check("req_ready", req_ready, e_rdy);
      check("busy", busy, m_busy);
      check("grant_id", grant_id, m_gid);
      e_rv = '0;
      if (m_busy && m_age >= 2) e_rv[m_id] = 1'b1;
      check("rsp_valid", rsp_valid, e_rv);
      if (e_rv != '0) begin
        if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
        else begin
          check("rsp_payload", {rsp_err, rsp_zero, rsp_result}, exp_q[0]);
          if (rsp_ready[m_id]) begin
            void'(exp_q.pop_front());
            m_busy = 1'b0;
            m_ptr  = (m_id + 1) % NUM_REQ;
          end
        end
      end
      acc = req_valid & req_ready;
      if (g >= 0) begin
        m_id = g; m_gid = g; m_busy = 1'b1; m_age = 0;
        exp_q.push_back(ref_alu(req_a[32*g +: 32], req_b[32*g +: 32], req_op[4*g +: 4]));
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    for (int i = 0; i < NUM_REQ; i++) rdy_mode[i] = 0;
    acc = '0; m_busy = 1'b0; m_ptr = 0; m_gid = 0; m_age = 0; m_id = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    // single op wrapping to zero
    push_op(0, 32'hFFFF_FFFF, 32'd1, 4'd0);
    drain(50);

    // round robin, all four contending
    for (int i = 0; i < NUM_REQ; i++) begin
      push_op(i, 32'h100 * (i + 1), 32'd7 + i, 4'd0);
      push_op(i, 32'h1000 + i, 32'd3, 4'd0);
    end
    drain(200);

    // backpressure on requester 2 while requester 0 waits
    rdy_mode[2] = 1;
    push_op(2, 32'd5, 32'd7, 4'd1);
    wait_rsp(2, 20);
    push_op(0, 32'h55, 32'hAA, 4'd3);
    repeat (10) @(posedge clk);
    #1;
    rdy_mode[2] = 0;
    drain(100);

    // shift boundaries and illegal opcodes
    push_op(0, 32'd1, 32'h3F, 4'd6);
    push_op(1, 32'h8000_0000, 32'd32, 4'd7);
    push_op(3, 32'h1234, 32'h5678, 4'hA);
    push_op(2, 32'h1, 32'h1, 4'h5);
    push_op(2, 32'hDEAD, 32'hBEEF, 4'hF);
    drain(200);

    // randomised traffic with random response backpressure
    for (int i = 0; i < NUM_REQ; i++) rdy_mode[i] = 2;
    for (int n = 0; n < 80; n++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      push_op($urandom_range(0, NUM_REQ - 1), ra, rb, 4'($urandom_range(0, 15)));
    end
    drain(5000);

    // reset while a response is pending
    for (int i = 0; i < NUM_REQ; i++) rdy_mode[i] = 0;
    rdy_mode[1] = 1;
    push_op(1, 32'd9, 32'd9, 4'd0);
    wait_rsp(1, 20);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();
    rst = 1'b0;
    rdy_mode[1] = 0;
    push_op(3, 32'd3, 32'd4, 4'd2);
    drain(50);
    push_op(0, 32'd10, 32'd20, 4'd4);
    push_op(3, 32'd30, 32'd40, 4'd0);
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
